// File: rtl/lms_ctr_led_sequencer.sv
// Avalon-MM LED pattern sequencer: up to NSTEPS pattern/dwell steps, one-shot or loop.
// Optional PWM dimming (BRIGHT register) when LMS_CTR_LED_SEQ_PWM_EN is defined.
module lms_ctr_led_sequencer #(
   parameter int PRESCALE_W = 16,
   parameter int DWELL_W    = 16,
   parameter int NSTEPS     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  out_port,
   output logic        busy,
   output logic        done_irq
);

   localparam int IW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
   localparam logic [2:0] LAST_MASK = 3'(NSTEPS - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                state_q, state_d;
   logic                  enable_q, enable_d;
   logic                  loop_q, loop_d;
   logic [2:0]            last_q, last_d;
   logic                  done_q, done_d;
   logic                  irq_q, irq_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [7:0]            manual_q, manual_d;
   logic [7:0]            pat_q [NSTEPS];
   logic [7:0]            pat_d [NSTEPS];
   logic [DWELL_W-1:0]    dwl_q [NSTEPS];
   logic [DWELL_W-1:0]    dwl_d [NSTEPS];
   logic [2:0]            step_q, step_d;
   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [PRESCALE_W-1:0] pre_lim_q, pre_lim_d;
   logic [DWELL_W-1:0]    dwell_cnt_q, dwell_cnt_d;
   logic [7:0]            cur_pat_q, cur_pat_d;

   logic                  wr_en;
   logic                  tick;
   logic [2:0]            nxt_step;
   logic [7:0]            base;
   logic                  unused_wd;

`ifdef LMS_CTR_LED_SEQ_PWM_EN
   logic [7:0]            bright_q, bright_d;
   logic [7:0]            pwm_cnt_q;
`endif

   assign wr_en     = chipselect && !write_n;
   assign unused_wd = ^writedata;

   function automatic logic [DWELL_W-1:0] dfix(input logic [DWELL_W-1:0] d);
      return (d == '0) ? DWELL_W'(1) : d;
   endfunction

   always_comb begin
      state_d     = state_q;
      enable_d    = enable_q;
      loop_d      = loop_q;
      last_d      = last_q;
      done_d      = done_q;
      irq_d       = 1'b0;
      prescale_d  = prescale_q;
      manual_d    = manual_q;
      pat_d       = pat_q;
      dwl_d       = dwl_q;
      step_d      = step_q;
      pre_cnt_d   = pre_cnt_q;
      pre_lim_d   = pre_lim_q;
      dwell_cnt_d = dwell_cnt_q;
      cur_pat_d   = cur_pat_q;
`ifdef LMS_CTR_LED_SEQ_PWM_EN
      bright_d    = bright_q;
`endif
      nxt_step    = step_q + 3'd1;
      tick        = (pre_cnt_q == pre_lim_q);

      if (state_q == S_RUN) begin
         if (tick) begin
            // new PRESCALE values take effect only at a wrap
            pre_cnt_d = '0;
            pre_lim_d = prescale_q;
            if (dwell_cnt_q <= DWELL_W'(1)) begin
               if (step_q < last_q) begin
                  step_d      = nxt_step;
                  dwell_cnt_d = dfix(dwl_q[nxt_step[IW-1:0]]);
                  cur_pat_d   = pat_q[nxt_step[IW-1:0]];
               end else if (loop_q) begin
                  step_d      = 3'd0;
                  dwell_cnt_d = dfix(dwl_q[0]);
                  cur_pat_d   = pat_q[0];
               end else begin
                  state_d = S_IDLE;
                  step_d  = 3'd0;
                  done_d  = 1'b1;
                  irq_d   = 1'b1;
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
            end
         end else begin
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
         end
      end

      if (wr_en) begin
         unique case (1'b1)
            (address == 4'd0): begin
               enable_d = writedata[0];
               loop_d   = writedata[1];
               last_d   = writedata[6:4] & LAST_MASK;
               if (writedata[3] || !writedata[0]) begin
                  state_d = S_IDLE;
                  step_d  = 3'd0;
                  done_d  = done_q;
                  irq_d   = 1'b0;
               end else if (writedata[2]) begin
                  state_d     = S_RUN;
                  step_d      = 3'd0;
                  pre_cnt_d   = '0;
                  pre_lim_d   = prescale_q;
                  dwell_cnt_d = dfix(dwl_q[0]);
                  cur_pat_d   = pat_q[0];
                  done_d      = 1'b0;
                  irq_d       = 1'b0;
               end
            end
            (address == 4'd1): begin
               if (writedata[8]) done_d = 1'b0;
            end
            (address == 4'd2): prescale_d = writedata[PRESCALE_W-1:0];
            (address == 4'd3): manual_d = writedata[7:0];
`ifdef LMS_CTR_LED_SEQ_PWM_EN
            (address == 4'd4): bright_d = writedata[7:0];
`endif
            address[3]: begin
               if ({1'b0, address[2:0]} < 4'(NSTEPS)) begin
                  pat_d[address[IW-1:0]] = writedata[7:0];
                  dwl_d[address[IW-1:0]] = writedata[DWELL_W+7:8];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         enable_q    <= 1'b0;
         loop_q      <= 1'b0;
         last_q      <= 3'd0;
         done_q      <= 1'b0;
         irq_q       <= 1'b0;
         prescale_q  <= '0;
         manual_q    <= 8'h00;
         step_q      <= 3'd0;
         pre_cnt_q   <= '0;
         pre_lim_q   <= '0;
         dwell_cnt_q <= '0;
         cur_pat_q   <= 8'h00;
         for (int i = 0; i < NSTEPS; i++) begin
            pat_q[i] <= 8'h00;
            dwl_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         enable_q    <= enable_d;
         loop_q      <= loop_d;
         last_q      <= last_d;
         done_q      <= done_d;
         irq_q       <= irq_d;
         prescale_q  <= prescale_d;
         manual_q    <= manual_d;
         step_q      <= step_d;
         pre_cnt_q   <= pre_cnt_d;
         pre_lim_q   <= pre_lim_d;
         dwell_cnt_q <= dwell_cnt_d;
         cur_pat_q   <= cur_pat_d;
         pat_q       <= pat_d;
         dwl_q       <= dwl_d;
      end
   end

`ifdef LMS_CTR_LED_SEQ_PWM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         bright_q  <= 8'hFF;
         pwm_cnt_q <= 8'h00;
      end else begin
         bright_q  <= bright_d;
         pwm_cnt_q <= pwm_cnt_q + 8'd1;
      end
   end
`endif

   assign busy     = (state_q == S_RUN);
   assign done_irq = irq_q;
   assign base     = busy ? cur_pat_q : manual_q;

`ifdef LMS_CTR_LED_SEQ_PWM_EN
   assign out_port = base & {8{pwm_cnt_q < bright_q}};
`else
   assign out_port = base;
`endif

   always_comb begin
      readdata = 32'h0;
      unique case (1'b1)
         (address == 4'd0): begin
            readdata[0]   = enable_q;
            readdata[1]   = loop_q;
            readdata[6:4] = last_q;
         end
         (address == 4'd1): begin
            readdata[0]   = busy;
            readdata[6:4] = step_q;
            readdata[8]   = done_q;
         end
         (address == 4'd2): readdata[PRESCALE_W-1:0] = prescale_q;
         (address == 4'd3): readdata[7:0] = manual_q;
`ifdef LMS_CTR_LED_SEQ_PWM_EN
         (address == 4'd4): readdata[7:0] = bright_q;
`endif
         address[3]: begin
            if ({1'b0, address[2:0]} < 4'(NSTEPS)) begin
               readdata[7:0]         = pat_q[address[IW-1:0]];
               readdata[DWELL_W+7:8] = dwl_q[address[IW-1:0]];
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lms_ctr_led_sequencer.sv
// Bench for lms_ctr_led_sequencer: expected LED timelines are built from step
// durations ((PRESCALE+1) * max(dwell,1) clocks per step) and compared per cycle.
module tb_lms_ctr_led_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;
   logic        busy;
   logic        done_irq;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] m_pat [8];
   int         m_dw  [8];
   int         m_pre;
   logic [7:0] m_man;
   logic [7:0] pwm_m;
`ifdef LMS_CTR_LED_SEQ_PWM_EN
   logic [7:0] m_bright;
`endif

   lms_ctr_led_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .busy       (busy),
      .done_irq   (done_irq)
   );

   always #5 clk = ~clk;

   // free-running PWM phase: counts clocks since reset release
   always @(posedge clk) begin
      if (reset) pwm_m <= 8'h00;
      else       pwm_m <= pwm_m + 8'd1;
   end

   function automatic logic [7:0] exp_led(input logic [7:0] b);
`ifdef LMS_CTR_LED_SEQ_PWM_EN
      return (pwm_m < m_bright) ? b : 8'h00;
`else
      return b;
`endif
   endfunction

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic load_model(input int nsteps);
      wr(4'd2, 32'(m_pre));
      for (int s = 0; s < nsteps; s++)
         wr(4'(8 + s), {8'h00, 16'(m_dw[s]), m_pat[s]});
   endtask

   task automatic run_and_check(input string name, input bit lp,
                                input int last, input int ncyc);
      int q[$];
      int len;
      int nchk;
      logic [7:0] eo;
      logic eb, ei;
      do begin
         for (int s = 0; s <= last; s++) begin
            int d;
            d = (m_dw[s] == 0) ? 1 : m_dw[s];
            for (int c = 0; c < (m_pre + 1) * d; c++) q.push_back(int'(m_pat[s]));
         end
      end while (lp && q.size() < ncyc);
      len = q.size();
      wr(4'd0, 32'((last << 4) | 4 | (int'(lp) << 1) | 1));
      nchk = lp ? ncyc : len + 2;
      for (int k = 0; k < nchk; k++) begin
         eo = exp_led((k < len) ? 8'(q[k]) : m_man);
         eb = lp || (k < len);
         ei = !lp && (k == len);
         n_cmp++;
         if (out_port !== eo) begin
            n_err++;
            $display("FAIL %s out_port cyc=%0d got=%h exp=%h", name, k, out_port, eo);
         end
         n_cmp++;
         if (busy !== eb) begin
            n_err++;
            $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, k, busy, eb);
         end
         n_cmp++;
         if (done_irq !== ei) begin
            n_err++;
            $display("FAIL %s done_irq cyc=%0d got=%b exp=%b", name, k, done_irq, ei);
         end
         @(negedge clk);
      end
   endtask

   task automatic check_idle(input string name, input logic exp_done);
      logic [31:0] st;
      n_cmp++;
      if (out_port !== exp_led(m_man) || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s idle out=%h busy=%b exp out=%h busy=0",
                  name, out_port, busy, exp_led(m_man));
      end
      rd(4'd1, st);
      n_cmp++;
      if ((st & 32'h101) !== {23'h0, exp_done, 8'h00}) begin
         n_err++;
         $display("FAIL %s status got=%h exp_done=%b", name, st, exp_done);
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      n_cmp++;
      if (out_port !== 8'h00 || busy !== 1'b0 || done_irq !== 1'b0) begin
         n_err++;
         $display("FAIL reset outputs got out=%h busy=%b irq=%b exp 00/0/0",
                  out_port, busy, done_irq);
      end
      for (int a = 0; a < 4; a++) begin
         rd(4'(a), v);
         n_cmp++;
         if (v !== 32'h0) begin
            n_err++;
            $display("FAIL reset reg%0d got=%h exp=0", a, v);
         end
      end
      rd(4'd8, v);
      n_cmp++;
      if (v !== 32'h0) begin
         n_err++;
         $display("FAIL reset step0 got=%h exp=0", v);
      end
   endtask

   task automatic test_manual();
      logic [31:0] v;
      m_man = 8'hA5;
      wr(4'd3, 32'hA5);
      check_idle("manual_a5", 1'b0);
      rd(4'd1, v);
      n_cmp++;
      if (v !== 32'h0) begin
         n_err++;
         $display("FAIL manual status got=%h exp=0", v);
      end
      for (int i = 0; i < 4; i++) begin
         m_man = 8'($urandom);
         wr(4'd3, {24'($urandom), m_man});
         check_idle("manual_rand", 1'b0);
      end
      wr(4'd5, $urandom);
      rd(4'd5, v);
      n_cmp++;
      if (v !== 32'h0) begin
         n_err++;
         $display("FAIL unmapped read got=%h exp=0", v);
      end
`ifndef LMS_CTR_LED_SEQ_PWM_EN
      wr(4'd4, 32'h55);
      rd(4'd4, v);
      n_cmp++;
      if (v !== 32'h0) begin
         n_err++;
         $display("FAIL addr4 read got=%h exp=0", v);
      end
`endif
      m_man = 8'h3C;
      wr(4'd3, 32'h3C);
   endtask

   task automatic setup_plan();
      m_pre    = 3;
      m_pat[0] = 8'h01;
      m_dw[0]  = 2;
      m_pat[1] = 8'h80;
      m_dw[1]  = 1;
      load_model(2);
   endtask

   task automatic test_oneshot();
      setup_plan();
      run_and_check("oneshot", 1'b0, 1, 0);
      check_idle("oneshot_done", 1'b1);
      wr(4'd1, 32'h100);
      check_idle("done_clear", 1'b0);
   endtask

   task automatic test_loop();
      wr(4'd1, 32'h0);
      setup_plan();
      run_and_check("loop", 1'b1, 1, 36);
      wr(4'd0, 32'h0B);
      check_idle("loop_stop", 1'b0);
      run_and_check("loop2", 1'b1, 1, 5);
      wr(4'd0, 32'h02);
      check_idle("loop_disable", 1'b0);
   endtask

   task automatic test_boundary();
      m_pre = 0;
      for (int s = 0; s < 8; s++) begin
         m_pat[s] = 8'($urandom);
         m_dw[s]  = 0;
      end
      load_model(8);
      run_and_check("wrap7", 1'b1, 7, 20);
      wr(4'd0, 32'h08);
      check_idle("wrap_stop", 1'b0);
      wr(4'd0, 32'h0D);
      check_idle("start_stop", 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int last;
         m_pre = $urandom_range(0, 3);
         for (int s = 0; s < 8; s++) begin
            m_pat[s] = 8'($urandom);
            m_dw[s]  = $urandom_range(0, 3);
         end
         last = $urandom_range(0, 7);
         load_model(8);
         run_and_check("random", 1'b0, last, 0);
         check_idle("random_done", 1'b1);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] v;
      setup_plan();
      wr(4'd0, 32'h15);
      repeat (9) @(negedge clk);
      n_cmp++;
      if (out_port !== exp_led(8'h80)) begin
         n_err++;
         $display("FAIL midrun step1 got=%h exp=%h", out_port, exp_led(8'h80));
      end
      reset = 1'b1;
      @(negedge clk);
      rd(4'd1, v);
      n_cmp++;
      if (out_port !== 8'h00 || busy !== 1'b0 || v !== 32'h0) begin
         n_err++;
         $display("FAIL midrun reset got out=%h busy=%b status=%h exp 00/0/0",
                  out_port, busy, v);
      end
      reset = 1'b0;
`ifdef LMS_CTR_LED_SEQ_PWM_EN
      m_bright = 8'hFF;
`endif
      m_man = 8'h00;
      @(negedge clk);
   endtask

`ifdef LMS_CTR_LED_SEQ_PWM_EN
   task automatic test_pwm();
      logic [31:0] v;
      int on;
      rd(4'd4, v);
      n_cmp++;
      if (v !== 32'hFF) begin
         n_err++;
         $display("FAIL bright reset got=%h exp=ff", v);
      end
      m_man = 8'hFF;
      wr(4'd3, 32'hFF);
      m_bright = 8'd64;
      wr(4'd4, 32'd64);
      on = 0;
      for (int k = 0; k < 256; k++) begin
         if (out_port === 8'hFF) on++;
         n_cmp++;
         if (out_port !== exp_led(m_man)) begin
            n_err++;
            $display("FAIL pwm64 cyc=%0d got=%h exp=%h", k, out_port, exp_led(m_man));
         end
         @(negedge clk);
      end
      n_cmp++;
      if (on != 64) begin
         n_err++;
         $display("FAIL pwm64 on_count got=%0d exp=64", on);
      end
      m_bright = 8'd0;
      wr(4'd4, 32'd0);
      on = 0;
      for (int k = 0; k < 256; k++) begin
         if (out_port !== 8'h00) on++;
         @(negedge clk);
      end
      n_cmp++;
      if (on != 0) begin
         n_err++;
         $display("FAIL pwm0 on_count got=%0d exp=0", on);
      end
   endtask
`endif

   initial begin
      reset      = 1'b1;
      address    = 4'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      m_man      = 8'h00;
      m_pre      = 0;
      for (int s = 0; s < 8; s++) begin
         m_pat[s] = 8'h00;
         m_dw[s]  = 0;
      end
`ifdef LMS_CTR_LED_SEQ_PWM_EN
      m_bright = 8'hFF;
`endif
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_manual();
      test_oneshot();
      test_loop();
      test_boundary();
      test_random();
      test_reset_mid_run();
`ifdef LMS_CTR_LED_SEQ_PWM_EN
      test_pwm();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lms_ctr_led_sequencer.md
Name: lms_ctr_led_sequencer

Overview:
- Avalon-MM slave LED pattern sequencer that sits in front of the board LEDs in the lms_ctr subsystem and replaces direct PIO writes for status indication.
- CPU loads up to 8 pattern steps, each with a dwell time, then starts the sequence; the block steps through them once or in a loop.
- When idle, the LEDs show a CPU-written manual value.

Parameters:
- PRESCALE_W, 16, width of prescaler register; one tick = PRESCALE+1 clk cycles
- DWELL_W, 16, width of per-step dwell field, in ticks
- NSTEPS, 8, pattern table depth (power of 2, max 8)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- address  in  4  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address, zero wait states
- out_port  out  8  LED drive
- busy  out  1  high while sequence running
- done_irq  out  1  one-cycle pulse when a non-loop sequence completes

Behaviour:
- One clock; reset is synchronous and active-high. All state is cleared on the clk edge while reset=1.
- Reset values: out_port=0, busy=0, done_irq=0, all registers 0, state IDLE.
- Writes take effect when chipselect && !write_n; the new value is visible on the next cycle.
- Reads of unmapped addresses return 0.
- Register map:
  - 0 CTRL: [0] enable, [1] loop, [2] start (write-1 pulse, reads 0), [3] stop (write-1 pulse, reads 0), [6:4] last step index.
  - 1 STATUS (RO): [0] busy, [6:4] current step, [8] done sticky. Done is cleared by start or by writing 1 to bit 8.
  - 2 PRESCALE: [PRESCALE_W-1:0].
  - 3 MANUAL: [7:0] value shown while idle.
  - 8+i STEP i: [7:0] pattern, [DWELL_W+7:8] dwell.
- State machine:
  - IDLE: out_port=MANUAL. Start with enable=1 → RUN: step=0, prescaler=0, dwell counter loaded from STEP0, done cleared. Start with enable=0 is ignored.
  - RUN: out_port=pattern[step], registered, valid the cycle after RUN is entered. The prescaler counts 0..PRESCALE and a tick fires on wrap. Each tick decrements the dwell counter. A dwell value of 0 is treated as 1.
  - Step expiry (dwell counter at 1 when a tick fires):
    - If step<last: step+1 and reload the dwell counter.
    - If step==last and loop=1: step=0.
    - If step==last and loop=0: go to IDLE, set done, pulse done_irq for 1 cycle.
  - Stop, or enable written 0, → IDLE immediately, with no done and no irq.
  - Start while in RUN restarts from step 0.
- Simultaneous events: stop beats start in the same write. A CPU write to the STEP register being displayed changes the outputs only at the next reload, since pattern and dwell are latched at step entry. A PRESCALE write while running applies at the next prescaler wrap.
- Last index ≥ NSTEPS is masked to NSTEPS-1.
- With PRESCALE=0 and all dwell=1, each step lasts exactly 1 clk.
- Reset asserted mid-RUN returns to IDLE with out_port=0 on the next cycle.

Optional Feature:
- Macro LMS_CTR_LED_SEQ_PWM_EN.
- Defined:
  - Register 4 BRIGHT [7:0] is added.
  - A free-running 8-bit counter runs on every clk, also in IDLE.
  - out_port = base & {8{pwm_cnt < BRIGHT}}. BRIGHT=0 gives all off and BRIGHT=255 gives off 1/256 of the time. BRIGHT resets to 255.
- Undefined:
  - Address 4 reads 0 and writes are ignored.
  - out_port = base directly, with no counter logic.

Test Plan:
- Reset then idle: write MANUAL=0xA5 → out_port=0xA5 the next cycle; STATUS reads 0.
- One-shot run: PRESCALE=3, STEP0={0x01,dwell 2}, STEP1={0x80,dwell 1}, CTRL=enable|start|last=1.
  - Required: out_port=0x01 for 8 clk, then 0x80 for 4 clk, then MANUAL.
  - Required: done_irq pulses once and STATUS[8]=1.
- Loop: same setup with loop=1 → pattern 0x01,0x80 repeats with a 12-clk period and busy stays 1. Stop write → IDLE the next cycle, done=0.
- Boundaries: dwell=0 and PRESCALE=0 → 1-clk steps. last=7 with 8 steps → wraps from step 7 to step 0. Start+stop in the same write → remains IDLE.
- Reset mid-run: assert reset during step 1 → out_port=0, busy=0, STATUS=0 the next cycle.
- PWM (macro defined): BRIGHT=64, pattern 0xFF → out_port high 64 of every 256 cycles. BRIGHT=0 → always 0.
